serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 10 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    input  logic         start,
    output logic         ready,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          br_q, br_d;
    logic          bout_q, bout_d;
    logic          fs_d, fs_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = fs_bout;
                diff_d = {fs_d, diff_q[N-1:1]};
                // Counter parks on the last value so it never wraps.
                if (cnt_q == LAST) begin
                    bout_d  = fs_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign Diff  = diff_q;
    assign Bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with N=4.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         N_RESET = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         start = 1'b0;
    logic         ready;
    logic [N-1:0] Diff;
    logic         Bout;
    logic         done;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.N(N)) dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .A       (A),
        .B       (B),
        .Bin     (Bin),
        .start   (start),
        .ready   (ready),
        .Diff    (Diff),
        .Bout    (Bout),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, scramble inputs after capture, check timing.
    task automatic run(input logic [3:0] a, input logic [3:0] b,
                       input logic bi, output logic [3:0] d,
                       output logic bo);
        @(negedge CLK);
        chk("ready_idle", 32'(ready), 1);
        A = a; B = b; Bin = bi; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; A = ~a; B = ~b; Bin = ~bi;
        chk("ready_shift", 32'(ready), 0);
        for (int i = 1; i < N; i++) begin
            @(negedge CLK);
            chk("no_early_done", 32'(done), 0);
        end
        @(negedge CLK);
        chk("done_pulse", 32'(done), 1);
        d = Diff;
        bo = Bout;
        @(negedge CLK);
        chk("done_one_cycle", 32'(done), 0);
        chk("ready_after", 32'(ready), 1);
    endtask

    initial begin
        logic [3:0] d;
        logic       bo;
        logic [3:0] nb;
        logic [4:0] e;
        int         c;

        // Reset state
        #2;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(Diff), 0);
        chk("rst_bout", 32'(Bout), 0);
        @(negedge CLK);
        N_RESET = 1'b1;

        // 9 - 3 - 0
        run(4'd9, 4'd3, 1'b0, d, bo);
        chk("9m3_diff", 32'(d), 6);
        chk("9m3_bout", 32'(bo), 0);

        // 3 - 9 - 0, then 0 - 0 - 1
        run(4'd3, 4'd9, 1'b0, d, bo);
        chk("3m9_diff", 32'(d), 10);
        chk("3m9_bout", 32'(bo), 1);
        run(4'd0, 4'd0, 1'b1, d, bo);
        chk("0m0b_diff", 32'(d), 15);
        chk("0m0b_bout", 32'(bo), 1);

        // Reset in the middle of SHIFT
        @(negedge CLK);
        A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        #2 N_RESET = 1'b0;
        #1;
        chk("midrst_diff", 32'(Diff), 0);
        chk("midrst_bout", 32'(Bout), 0);
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("midrst_no_done", 32'(done), 0);
        end
        N_RESET = 1'b1;

        // 15 - 15, then hold through idle cycles
        run(4'd15, 4'd15, 1'b0, d, bo);
        chk("15m15_diff", 32'(d), 0);
        chk("15m15_bout", 32'(bo), 0);
        run(4'd2, 4'd7, 1'b0, d, bo);
        chk("2m7_diff", 32'(d), 11);
        chk("2m7_bout", 32'(bo), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("hold_diff", 32'(Diff), 11);
            chk("hold_bout", 32'(Bout), 1);
        end

        // Start during SHIFT is ignored
        @(negedge CLK);
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        A = 4'd1; B = 4'd1; Bin = 1'b1; start = 1'b1;
        chk("busy_ready", 32'(ready), 0);
        @(negedge CLK);
        chk("busy_no_done", 32'(done), 0);
        chk("busy_ready2", 32'(ready), 0);
        @(negedge CLK);
        chk("busy_no_done2", 32'(done), 0);
        start = 1'b0;
        @(negedge CLK);
        chk("busy_done", 32'(done), 1);
        chk("busy_diff", 32'(Diff), 6);
        chk("busy_bout", 32'(Bout), 0);
        @(negedge CLK);
        chk("busy_idle", 32'(ready), 1);
        @(negedge CLK);
        chk("busy_not_queued", 32'(ready), 1);

        // Back-to-back with start held high
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        c = 0;
        while (!done && c < 20) begin
            @(negedge CLK);
            c++;
        end
        chk("b2b_first_done", 32'(done), 1);
        c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (!done && c < 20);
        chk("b2b_period", 32'(c), N + 2);
        chk("b2b_diff", 32'(Diff), 6);
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        // Exhaustive sweep against an adder model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    run(4'(a), 4'(b), 1'(bi), d, bo);
                    nb = ~4'(b);
                    e = {1'b0, 4'(a)} + {1'b0, nb} + {4'b0, ~1'(bi)};
                    chk("sweep", 32'({~bo, d}), 32'(e));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
